tri_fetch_queue: RTL and testbench

Parametrised triangle fetch engine with an internal prefetch FIFO, sitting between triangle memory and the intersection pipeline. On `start` it issues single-outstanding memory reads and stores each returned triangle with a sequential `triangle_id`. Results go to the consumer over a valid/ready interface. Fetching stops at a zero-`sid` sentinel, and `done` is raised once every buffered triangle has been consumed.

---
 rtl/tri_fetch_queue_if.sv | 62 ++++++
 rtl/tri_fetch_queue.sv | 191 +++++++++++++++++++
 tb/tb_tri_fetch_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// tri_fetch_queue_if
//   Bundles the memory read channel and the triangle output stream of
//   tri_fetch_queue into one interface.
//
//   Memory channel : mem_req, mem_busy, mem_rdy, mem_v0/1/2, mem_sid
//   Output stream  : tri_valid, tri_ready, v0/1/2_out, sid_out, triangle_id
//   Status         : level (FIFO occupancy), done (list exhausted + drained)
//
//   Modports:
//     master : the fetch engine (drives mem_req and the output stream)
//     slave  : the environment (memory + consumer)
// ---------------------------------------------------------------------------
interface tri_fetch_queue_if #(
    parameter int NUM_TRIANGLE = 512,
    parameter int DEPTH        = 4,
    parameter int VERT_W       = 96,
    parameter int SID_W        = 32
);
    localparam int ID_W  = $clog2(NUM_TRIANGLE);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // memory read channel
    logic              mem_req;
    logic              mem_busy;
    logic              mem_rdy;
    logic [VERT_W-1:0] mem_v0;
    logic [VERT_W-1:0] mem_v1;
    logic [VERT_W-1:0] mem_v2;
    logic [SID_W-1:0]  mem_sid;

    // triangle output stream
    logic              tri_valid;
    logic              tri_ready;
    logic [VERT_W-1:0] v0_out;
    logic [VERT_W-1:0] v1_out;
    logic [VERT_W-1:0] v2_out;
    logic [SID_W-1:0]  sid_out;
    logic [ID_W-1:0]   triangle_id;

    // status
    logic [LVL_W-1:0]  level;
    logic              done;

    modport master (
        output mem_req,
        input  mem_busy, mem_rdy, mem_v0, mem_v1, mem_v2, mem_sid,
        output tri_valid,
        input  tri_ready,
        output v0_out, v1_out, v2_out, sid_out, triangle_id,
        output level, done
    );

    modport slave (
        input  mem_req,
        output mem_busy, mem_rdy, mem_v0, mem_v1, mem_v2, mem_sid,
        input  tri_valid,
        output tri_ready,
        input  v0_out, v1_out, v2_out, sid_out, triangle_id,
        input  level, done
    );
endinterface

// File: rtl/tri_fetch_queue.sv
// ---------------------------------------------------------------------------
// tri_fetch_queue
//   Triangle fetch engine with a first-word-fall-through prefetch FIFO.
//   After `start` it issues single-outstanding reads to triangle memory,
//   tags every returned triangle with a sequential id and buffers it for the
//   intersection pipeline. A zero sid ends the list; `done` rises once the
//   FIFO has been drained.
//
//   Ports:
//     clk    : clock
//     rst    : asynchronous active-high reset
//     clear  : synchronous flush back to IDLE (drops an in-flight response)
//     start  : begin fetching (sampled in IDLE only)
//     bus    : tri_fetch_queue_if.master (memory channel, output stream,
//              level, done)
//
//   Optional feature macro: TRIQ_COUNT_LIMIT_EN
//     defined   : fetching also stops after NUM_TRIANGLE pushes (id never
//                 wraps)
//     undefined : only a zero sid stops fetching; id wraps modulo
//                 NUM_TRIANGLE
// ---------------------------------------------------------------------------
module tri_fetch_queue #(
    parameter int NUM_TRIANGLE = 512,
    parameter int DEPTH        = 4,
    parameter int VERT_W       = 96,
    parameter int SID_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                start,
    tri_fetch_queue_if.master   bus
);
    localparam int ID_W  = $clog2(NUM_TRIANGLE);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int ENT_W = 3 * VERT_W + SID_W + ID_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [ENT_W-1:0] fifo_q [DEPTH];
    logic [ENT_W-1:0] push_ent;
    logic [ENT_W-1:0] head_ent;

    logic             full;
    logic             req;
    logic             resp_valid_tri;
    logic             push;
    logic             pop;
    logic             id_last;
    logic             limit_hit;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign req      = (state_q == S_FETCH) && !bus.mem_busy && !full;
    assign id_last  = (id_q == ID_W'(NUM_TRIANGLE - 1));

    // A response is only meaningful in WAIT; FLUSH swallows it.
    assign resp_valid_tri = (state_q == S_WAIT) && bus.mem_rdy && (bus.mem_sid != '0);
    assign push           = resp_valid_tri && !clear;
    assign pop            = (level_q != '0) && bus.tri_ready && !clear;

`ifdef TRIQ_COUNT_LIMIT_EN
    // The push carrying the last id is the final one; treat it like a sentinel.
    assign limit_hit = id_last;
`else
    assign limit_hit = 1'b0;
`endif

    assign push_ent = {bus.mem_v0, bus.mem_v1, bus.mem_v2, bus.mem_sid, id_q};

    // ---------------------------------------------------------------------
    // Next-state / datapath control
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            // A response already on the bus this cycle is simply dropped, so
            // there is nothing left to wait for.
            if (state_q == S_WAIT && !bus.mem_rdy) begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: if (req) state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.mem_rdy) begin
                        if (bus.mem_sid == '0 || limit_hit) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DRAIN: if (level_q == '0) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                S_FLUSH: if (bus.mem_rdy) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        id_d     = id_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            id_d     = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                id_d     = id_last ? '0 : id_q + ID_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            id_q     <= id_d;
        end
    end

    // FIFO storage: reset so the head outputs read 0 after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_q[gi] <= '0;
                end else if (push && (wr_ptr_q == AW'(gi))) begin
                    fifo_q[gi] <= push_ent;
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Outputs (FWFT head read straight from storage)
    // ---------------------------------------------------------------------
    assign head_ent        = fifo_q[rd_ptr_q];
    assign bus.mem_req     = req;
    assign bus.tri_valid   = (level_q != '0);
    assign bus.v0_out      = head_ent[ENT_W-1 -: VERT_W];
    assign bus.v1_out      = head_ent[ENT_W-VERT_W-1 -: VERT_W];
    assign bus.v2_out      = head_ent[SID_W+ID_W +: VERT_W];
    assign bus.sid_out     = head_ent[ID_W +: SID_W];
    assign bus.triangle_id = head_ent[ID_W-1:0];
    assign bus.level       = level_q;
    assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_tri_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_tri_fetch_queue
//   Bench for tri_fetch_queue: memory responder and consumer driven from a
//   single initial block, expectations from a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_tri_fetch_queue;
    localparam int NT    = 8;
    localparam int DEPTH = 4;
    localparam int VW    = 96;
    localparam int SW    = 32;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic start;

    always #5 clk = ~clk;

    tri_fetch_queue_if #(.NUM_TRIANGLE(NT), .DEPTH(DEPTH), .VERT_W(VW), .SID_W(SW)) bus ();

    tri_fetch_queue #(.NUM_TRIANGLE(NT), .DEPTH(DEPTH), .VERT_W(VW), .SID_W(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .start (start),
        .bus   (bus)
    );

    typedef struct {
        logic [SW-1:0] sid;
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        int            id;
    } ent_t;

    ent_t          exp_q[$];
    logic [SW-1:0] mem_sid_l[$];
    logic [VW-1:0] mem_v0_l[$];
    logic [VW-1:0] mem_v1_l[$];
    logic [VW-1:0] mem_v2_l[$];
    int            mem_idx;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // reference-model state
    bit active, term, drop, pend, done_m;
    int term_cyc, resp_cyc, pend_idx, id_m, pushed, delivered, req_cnt;

    // stimulus knobs
    bit clr_req, start_req;
    int ready_mode;   // 0, 1, or 2 = random
    int busy_pct;
    int lat_fix;      // 0 = random latency 1..3

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [VW-1:0] rnd_v();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef TRIQ_COUNT_LIMIT_EN
        return (n > NT) ? NT : n;
`else
        return n;
`endif
    endfunction

    task automatic clear_mem();
        mem_sid_l.delete(); mem_v0_l.delete(); mem_v1_l.delete(); mem_v2_l.delete();
        mem_idx = 0;
    endtask

    task automatic add_tri(input logic [SW-1:0] s);
        mem_sid_l.push_back(s);
        mem_v0_l.push_back(rnd_v());
        mem_v1_l.push_back(rnd_v());
        mem_v2_l.push_back(rnd_v());
    endtask

    task automatic model_reset();
        exp_q.delete();
        id_m = 0; pushed = 0; done_m = 0; term = 0; active = 0;
    endtask

    // One clock cycle: drive inputs at negedge, check, update the model.
    task automatic tick();
        int   size;
        bit   exp_req;
        ent_t e;
        @(negedge clk);
        clear         = clr_req;
        start         = start_req;
        bus.mem_busy  = ($urandom_range(0, 99) < busy_pct);
        bus.tri_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : ready_mode[0];
        if (pend && cyc == resp_cyc) begin
            bus.mem_rdy = 1'b1;
            if (pend_idx < mem_sid_l.size()) begin
                bus.mem_sid = mem_sid_l[pend_idx];
                bus.mem_v0  = mem_v0_l[pend_idx];
                bus.mem_v1  = mem_v1_l[pend_idx];
                bus.mem_v2  = mem_v2_l[pend_idx];
            end else begin
                bus.mem_sid = '0;
                bus.mem_v0  = rnd_v();
                bus.mem_v1  = rnd_v();
                bus.mem_v2  = rnd_v();
            end
        end else begin
            bus.mem_rdy = 1'b0;
            bus.mem_sid = $urandom;
            bus.mem_v0  = rnd_v();
            bus.mem_v1  = rnd_v();
            bus.mem_v2  = rnd_v();
        end
        #1;
        size    = exp_q.size();
        exp_req = active && !pend && !drop && !term && !bus.mem_busy && (size < DEPTH);
        chk("mem_req", bus.mem_req, exp_req);
        chk("tri_valid", bus.tri_valid, size != 0);
        chk("level", bus.level, size);
        chk("done", bus.done, done_m);
        if (size > 0) begin
            chk("head_sid", bus.sid_out, exp_q[0].sid);
            chk("head_id", bus.triangle_id, exp_q[0].id);
            chk("head_v0", bus.v0_out, exp_q[0].v0);
            chk("head_v1", bus.v1_out, exp_q[0].v1);
            chk("head_v2", bus.v2_out, exp_q[0].v2);
        end
        if (bus.mem_req) req_cnt++;

        if (clr_req) begin
            model_reset();
            if (pend) begin
                if (bus.mem_rdy) begin
                    pend = 0;
                    drop = 0;
                end else begin
                    drop = 1;
                end
            end
        end else begin
            if (term && cyc >= term_cyc + 1 && size == 0) done_m = 1;
            if (size > 0 && bus.tri_ready) begin
                $display("pop  id=%0d sid=%0h", exp_q[0].id, exp_q[0].sid);
                void'(exp_q.pop_front());
                delivered++;
            end
            if (pend && bus.mem_rdy) begin
                pend = 0;
                if (drop) begin
                    drop = 0;
                end else if (bus.mem_sid != '0) begin
                    e.sid = bus.mem_sid; e.v0 = bus.mem_v0; e.v1 = bus.mem_v1; e.v2 = bus.mem_v2;
                    e.id  = id_m;
                    exp_q.push_back(e);
                    id_m = (id_m + 1) % NT;
                    pushed++;
`ifdef TRIQ_COUNT_LIMIT_EN
                    if (pushed == NT) begin
                        term = 1; term_cyc = cyc;
                    end
`endif
                end else begin
                    term = 1; term_cyc = cyc;
                end
            end
            if (start_req && !active && !drop && !pend) active = 1;
        end

        if (bus.mem_req) begin
            pend     = 1;
            pend_idx = mem_idx;
            mem_idx++;
            resp_cyc = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3)));
            if (clr_req) drop = 1;
        end
        cyc++;
    endtask

    task automatic go();
        delivered = 0;
        req_cnt   = 0;
        start_req = 1;
        tick();
        start_req = 0;
    endtask

    task automatic do_clear();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int n = 0; n < 20 && (pend || drop); n++) tick();
        chk("flush_bound", pend | drop, 1'b0);
    endtask

    task automatic run_until_done(input int budget);
        for (int n = 0; n < budget && !bus.done; n++) tick();
        chk("done_reached", bus.done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
        chk({tag, "_tri_valid"}, bus.tri_valid, 1'b0);
        chk({tag, "_level"}, bus.level, '0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_sid_out"}, bus.sid_out, '0);
        chk({tag, "_triangle_id"}, bus.triangle_id, '0);
        chk({tag, "_v0_out"}, bus.v0_out, '0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        pend = 0; drop = 0; clr_req = 0; start_req = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; clear = 1'b0; start = 1'b0;
        bus.mem_busy = 1'b0; bus.mem_rdy = 1'b0; bus.mem_sid = '0;
        bus.mem_v0 = '0; bus.mem_v1 = '0; bus.mem_v2 = '0; bus.tri_ready = 1'b0;
        model_reset();
        pend = 0; drop = 0; clr_req = 0; start_req = 0;
        ready_mode = 1; busy_pct = 0; lat_fix = 0;
        term_cyc = 0; resp_cyc = 0; pend_idx = 0; delivered = 0; req_cnt = 0;
        clear_mem();
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // basic list 5,6,7 then sentinel
        clear_mem(); add_tri(5); add_tri(6); add_tri(7);
        ready_mode = 1;
        go();
        run_until_done(100);
        chk("t1_delivered", delivered, 3);

        // back-pressure: FIFO fills to DEPTH, no further requests
        clear_mem();
        for (int i = 0; i < 6; i++) add_tri(SW'(10 + i));
        ready_mode = 0;
        do_clear();
        go();
        repeat (40) tick();
        chk("t2_req_count", req_cnt, DEPTH);
        chk("t2_level_full", bus.level, DEPTH);
        chk("t2_no_req_full", bus.mem_req, 1'b0);
        ready_mode = 1;
        run_until_done(200);
        chk("t2_delivered", delivered, 6);

        // mem_busy holds off requests
        clear_mem(); add_tri(30); add_tri(31); add_tri(32);
        busy_pct = 100;
        do_clear();
        go();
        repeat (10) tick();
        chk("t3_busy_no_req", req_cnt, 0);
        busy_pct = 0;
        tick();
        chk("t3_req_after_busy", bus.mem_req, 1'b1);
        run_until_done(100);
        chk("t3_delivered", delivered, 3);

        // clear while a response is in flight
        clear_mem(); add_tri(9); add_tri(20); add_tri(21);
        lat_fix = 4;
        do_clear();
        go();
        for (n = 0; n < 20 && !bus.mem_req; n++) tick();
        chk("t4_req_seen", bus.mem_req, 1'b1);
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (3) tick();
        chk("t4_level_after_flush", bus.level, '0);
        chk("t4_valid_after_flush", bus.tri_valid, 1'b0);
        lat_fix = 0;
        clear_mem(); add_tri(40); add_tri(41);
        go();
        for (n = 0; n < 20 && !bus.tri_valid; n++) tick();
        chk("t4_first_id", bus.triangle_id, '0);
        run_until_done(100);
        chk("t4_delivered", delivered, 2);

        // id wrap / count limit
        clear_mem();
        for (int i = 0; i < NT + 2; i++) add_tri(SW'(100 + i));
        do_clear();
        go();
        run_until_done(300);
        chk("t5_delivered", delivered, exp_cnt(NT + 2));

        // randomized lists with random ready / busy / latency
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            n = $urandom_range(6, 20);
            for (int i = 0; i < n; i++) add_tri(SW'($urandom_range(1, 1000)));
            ready_mode = 2; busy_pct = 30;
            do_clear();
            go();
            run_until_done(1500);
            chk("rand_delivered", delivered, exp_cnt(n));
        end

        // asynchronous reset in the middle of a burst
        clear_mem();
        for (int i = 0; i < 10; i++) add_tri(SW'(200 + i));
        ready_mode = 2; busy_pct = 0;
        do_clear();
        go();
        repeat (12) tick();
        async_reset();
        clear_mem(); add_tri(300); add_tri(301);
        ready_mode = 1;
        go();
        run_until_done(100);
        chk("t7_delivered", delivered, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
